// File: rtl/boot_mem_pkg.sv
// Shared constants for the multicycle MIPS core and its boot-loading memory.
package boot_mem_pkg;

    // boot_mem controller states
    typedef enum logic [1:0] {
        LOAD = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } boot_state_t;

    // Byte address whose store ends a program run
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'hFFFF_FFF0;

    // Core opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/ram_1w1r.sv
// Word array with one asynchronous read port and one synchronous write port.
module ram_1w1r
    import boot_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem [1 << ADDR_BITS];

    // Synchronous write; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/boot_mem.sv
// Unified core memory with a boot-load front end: fills memory from a
// valid/ready stream while holding the core in reset, then serves the core
// and stops it when a store hits the halt address.
module boot_mem
    import boot_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 6,
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        adr,
    input  logic [31:0]        writedata,
    input  logic               memwrite,
    output logic [31:0]        readdata,
    input  logic               load_valid,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               cpu_reset,
    output logic               halted,
    output logic [31:0]        result,
    output logic [ADDR_BITS:0] words_loaded
);

    boot_state_t          state;
    boot_state_t          next_state;
    logic [ADDR_BITS-1:0] load_ptr;

    logic                 load_fire;
    logic                 in_range;
    logic [ADDR_BITS-1:0] index;
    logic                 core_store;
    logic                 halt_hit;

    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;

    assign load_ready = (state == LOAD);
    assign load_fire  = load_valid & load_ready;

    assign in_range   = (adr[31:ADDR_BITS+2] == '0);
    assign index      = adr[ADDR_BITS+1:2];
    assign core_store = (state == RUN) & memwrite & in_range;
    assign halt_hit   = (state == RUN) & memwrite & (adr == HALT_ADDR);

    assign readdata   = ((state == RUN) && in_range) ? ram_rdata : '0;

    // Write port belongs to the loader in LOAD and to the core otherwise
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = index;
        ram_wdata = writedata;
        if (state == LOAD) begin
            ram_we    = load_fire;
            ram_waddr = load_ptr;
            ram_wdata = load_data;
        end else begin
            ram_we    = core_store;
        end
    end

    ram_1w1r #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(index),
        .rdata(ram_rdata)
    );

    // Next-state decode; the last array slot ends loading even without load_last
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (load_fire && (load_last || (load_ptr == '1))) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (halt_hit) begin
                    next_state = HALT;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = LOAD;
        endcase
    end

    // State, load bookkeeping and outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            load_ptr     <= '0;
            words_loaded <= '0;
            cpu_reset    <= 1'b1;
            halted       <= 1'b0;
            result       <= '0;
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state != RUN);
            halted    <= (next_state == HALT);
            if (load_fire) begin
                load_ptr     <= load_ptr + ADDR_BITS'(1);
                words_loaded <= words_loaded + (ADDR_BITS+1)'(1);
            end
            if (halt_hit) begin
                result <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_boot_mem.sv
// Directed self-checking bench for boot_mem.
module tb_boot_mem;

    localparam int unsigned AB = 6;

    logic        clk;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_reset;
    logic        halted;
    logic [31:0] result;
    logic [AB:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    boot_mem #(
        .ADDR_BITS(AB),
        .HALT_ADDR(32'hFFFF_FFF0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adr         (adr),
        .writedata   (writedata),
        .memwrite    (memwrite),
        .readdata    (readdata),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_reset   (cpu_reset),
        .halted      (halted),
        .result      (result),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        we;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] boot [3];
        int          accepted;
        logic        fired;

        boot[0] = 32'h2002_0005;
        boot[1] = 32'h2003_000C;
        boot[2] = 32'hAC03_0040;

        // RUN-phase vectors: {adr, wdata, we, chk, expected readdata}
        vecs[0]  = '{32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'hAC03_0040};
        vecs[1]  = '{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h2002_0005};
        vecs[2]  = '{32'h0000_0004, 32'h0,         1'b0, 1'b1, 32'h2003_000C};
        vecs[3]  = '{32'h0000_0009, 32'h0,         1'b0, 1'b1, 32'hAC03_0040};
        vecs[4]  = '{32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        vecs[6]  = '{32'h0000_0400, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h2002_0005};
        vecs[8]  = '{32'h0000_0400, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[9]  = '{32'h0000_0013, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[11] = '{32'hFFFF_FFF0, 32'h0,         1'b0, 1'b1, 32'h0};

        reset      = 1'b1;
        adr        = '0;
        writedata  = '0;
        memwrite   = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        step();
        step();

        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        reset = 1'b0;
        step();

        // Three-word boot, last flagged on the third
        adr = 32'h0000_0008;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = boot[i];
            load_last  = (i == 2);
            #1;
            check("load_readdata_zero", readdata, 32'h0);
            check("load_cpu_reset_held", 32'(cpu_reset), 32'd1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("boot3_cpu_reset", 32'(cpu_reset), 32'd0);
        check("boot3_words", 32'(words_loaded), 32'd3);
        check("boot3_ready", 32'(load_ready), 32'd0);

        // Table-driven RUN accesses
        for (int i = 0; i < 12; i++) begin
            adr       = vecs[i].adr;
            writedata = vecs[i].wdata;
            memwrite  = vecs[i].we;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp);
            check($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
            step();
            memwrite = 1'b0;
        end

        // Halt store, then stray stores and load beats must change nothing
        adr       = 32'hFFFF_FFF0;
        writedata = 32'h0000_0007;
        memwrite  = 1'b1;
        step();
        memwrite = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_result", result, 32'h7);
        check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        adr = 32'h0;
        #1;
        check("halt_readdata", readdata, 32'h0);
        writedata  = 32'h0000_0099;
        adr        = 32'hFFFF_FFF0;
        memwrite   = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h5555_5555;
        step();
        step();
        memwrite   = 1'b0;
        load_valid = 1'b0;
        check("halt_result_kept", result, 32'h7);
        check("halt_still", 32'(halted), 32'd1);
        check("halt_words_kept", 32'(words_loaded), 32'd3);
        check("halt_ready", 32'(load_ready), 32'd0);

        // Reset from HALT is immediate, then reset mid-load
        reset = 1'b1;
        #1;
        check("async_rst_halted", 32'(halted), 32'd0);
        check("async_rst_ready", 32'(load_ready), 32'd1);
        step();
        reset = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hA000_0000;
        step();
        load_data  = 32'hB000_0001;
        step();
        load_valid = 1'b0;
        check("midload_words", 32'(words_loaded), 32'd2);
        reset = 1'b1;
        #1;
        check("midload_rst_words", 32'(words_loaded), 32'd0);
        step();
        reset = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hC000_0002;
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("reload_words", 32'(words_loaded), 32'd1);
        check("reload_cpu_reset", 32'(cpu_reset), 32'd0);
        adr = 32'h0;
        #1;
        check("reload_mem0", readdata, 32'hC000_0002);
        adr = 32'h4;
        #1;
        check("reload_mem1_kept", readdata, 32'hB000_0001);

        // Asynchronous reset from RUN, mid-cycle
        reset = 1'b1;
        #1;
        check("async_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        reset = 1'b0;

        // Full-depth load with valid toggling and no load_last
        accepted = 0;
        for (int cyc = 0; cyc < 200 && accepted < 64; cyc++) begin
            load_valid = (cyc % 2 == 0);
            load_data  = load_valid ? (32'h1000_0000 + 32'(accepted)) : (32'hBAD0_0000 + 32'(cyc));
            load_last  = 1'b0;
            #1;
            fired = load_valid && load_ready;
            if (fired && accepted == 63) check("full_cpu_reset_before_last", 32'(cpu_reset), 32'd1);
            step();
            if (fired) accepted++;
        end
        load_valid = 1'b0;
        check("full_accepted", 32'(accepted), 32'd64);
        check("full_words", 32'(words_loaded), 32'd64);
        check("full_cpu_reset", 32'(cpu_reset), 32'd0);
        check("full_ready", 32'(load_ready), 32'd0);
        for (int i = 0; i < 64; i++) begin
            adr = 32'(i) << 2;
            #1;
            check($sformatf("full_mem%0d", i), readdata, 32'h1000_0000 + 32'(i));
        end

        // Load beats offered in RUN are ignored
        load_valid = 1'b1;
        load_data  = 32'h7777_7777;
        step();
        step();
        load_valid = 1'b0;
        adr = 32'h0;
        #1;
        check("run_words_kept", 32'(words_loaded), 32'd64);
        check("run_mem0_kept", readdata, 32'h1000_0000);

        // Core-style program end: store 7 to the halt address
        adr       = 32'hFFFF_FFF0;
        writedata = 32'h0000_0007;
        memwrite  = 1'b1;
        step();
        memwrite = 1'b0;
        check("e2e_halted", 32'(halted), 32'd1);
        check("e2e_result", result, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
